// File: rtl/uart_rx_framed.sv
// Oversampled UART receiver: parametrised frame format, 3-sample majority vote,
// per-word error flags and a valid/ready output with sticky overrun.
module uart_rx_framed #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  baudTick,
   input  logic                  rx,
   input  logic                  data_ready,
   input  logic                  clear_overrun,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  framing_error,
   output logic                  break_detect,
   output logic                  overrun_error,
   output logic                  rx_ready,
   output logic                  new_byte_start,
   output logic                  new_byte_received
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_sync;
   logic                  r_rx_s_d;
   logic [2:0]            r_vote;
   logic [TW-1:0]         r_tick;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_err, r_fr_err, r_stop0_low;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid, r_perr, r_ferr, r_brk, r_ovr, r_nbs, r_nbr;

   logic w_rx_s, w_voted, w_mid, w_end, w_start_ok, w_done;
   logic w_accept, w_stop_low, w_first_stop_low, w_brk;

   assign w_rx_s           = r_sync[1];
   assign w_voted          = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);
   assign w_mid            = baudTick && (r_tick == TICK_MID);
   assign w_end            = baudTick && (r_tick == TICK_END);
   assign w_accept         = r_valid && data_ready;
   assign w_stop_low       = ~w_voted;
   // With one stop bit the first stop sample is the one being taken right now.
   assign w_first_stop_low = (r_bit_cnt == '0) ? w_stop_low : r_stop0_low;
   assign w_brk            = w_done && (r_shift == '0) && w_first_stop_low;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_sync   <= 2'b11;
         r_rx_s_d <= 1'b1;
         r_vote   <= 3'b111;
      end else begin
         r_sync   <= {r_sync[0], rx};
         r_rx_s_d <= w_rx_s;
         if (baudTick) r_vote <= {r_vote[1:0], w_rx_s};
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE:   if (r_rx_s_d && !w_rx_s) w_state_nxt = S_START;
         S_START:  if (w_mid) begin
                      if (!w_voted) begin
                         w_state_nxt = S_DATA;
                         w_start_ok  = 1'b1;
                      end else begin
                         w_state_nxt = S_IDLE;
                      end
                   end
         S_DATA:   if (w_end && r_bit_cnt == BIT_LAST)
                      w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_end) w_state_nxt = S_STOP;
         S_STOP:   if (w_end && r_bit_cnt == STOP_LAST) begin
                      w_state_nxt = S_IDLE;
                      w_done      = 1'b1;
                   end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_tick      <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par_err   <= 1'b0;
         r_fr_err    <= 1'b0;
         r_stop0_low <= 1'b0;
      end else begin
         case (r_state)
            S_START: if (baudTick) begin
                        if (w_mid) begin
                           r_tick      <= '0;
                           r_bit_cnt   <= '0;
                           r_shift     <= '0;
                           r_par_err   <= 1'b0;
                           r_fr_err    <= 1'b0;
                           r_stop0_low <= 1'b0;
                        end else begin
                           r_tick <= r_tick + TW'(1);
                        end
                     end
            S_DATA:  if (baudTick) begin
                        if (w_end) begin
                           r_shift   <= {w_voted, r_shift[DATA_WIDTH-1:1]};
                           r_tick    <= '0;
                           r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
                        end else begin
                           r_tick <= r_tick + TW'(1);
                        end
                     end
            S_PARITY: if (baudTick) begin
                        if (w_end) begin
                           r_par_err <= (^r_shift) ^ w_voted ^ (PARITY_ODD != 0);
                           r_tick    <= '0;
                        end else begin
                           r_tick <= r_tick + TW'(1);
                        end
                     end
            S_STOP:  if (baudTick) begin
                        if (w_end) begin
                           if (w_stop_low) r_fr_err <= 1'b1;
                           if (r_bit_cnt == '0) r_stop0_low <= w_stop_low;
                           r_tick    <= '0;
                           r_bit_cnt <= r_bit_cnt + BW'(1);
                        end else begin
                           r_tick <= r_tick + TW'(1);
                        end
                     end
            default: begin
                        r_tick    <= '0;
                        r_bit_cnt <= '0;
                     end
         endcase
      end
   end

   // Output word, its flags and the consumer handshake.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_ovr   <= 1'b0;
         r_nbs   <= 1'b0;
         r_nbr   <= 1'b0;
      end else begin
         r_nbs <= w_start_ok;
         r_nbr <= w_done;
         r_brk <= w_brk;
         if (w_done) begin
            r_data  <= r_shift;
            r_perr  <= r_par_err;
            r_ferr  <= r_fr_err | w_stop_low;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (w_done && r_valid && !data_ready) r_ovr <= 1'b1;
         else if (clear_overrun)               r_ovr <= 1'b0;
      end
   end

   assign dataOut           = r_data;
   assign data_valid        = r_valid;
   assign parity_error      = r_perr;
   assign framing_error     = r_ferr;
   assign break_detect      = r_brk;
   assign overrun_error     = r_ovr;
   assign rx_ready          = (r_state == S_IDLE);
   assign new_byte_start    = r_nbs;
   assign new_byte_received = r_nbr;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three frame formats on one shared serial line,
// expected words and flags derived from the transmitted bit pattern.
module tb_uart_rx_framed;

   localparam int OS     = 16;
   localparam int TPB    = 4;
   localparam int BITCLK = OS * TPB;

   logic clk = 1'b0, rstN = 1'b0, baudTick = 1'b0, rx = 1'b1;
   logic data_ready = 1'b1, clear_overrun = 1'b0;

   logic [7:0] d0_data, d1_data;
   logic [6:0] d2_data;
   logic d0_v, d0_pe, d0_fe, d0_bk, d0_ov, d0_rdy, d0_nbs, d0_nbr;
   logic d1_v, d1_pe, d1_fe, d1_bk, d1_ov, d1_rdy, d1_nbs, d1_nbr;
   logic d2_v, d2_pe, d2_fe, d2_bk, d2_ov, d2_rdy, d2_nbs, d2_nbr;

   uart_rx_framed u_def (
      .clk(clk), .rstN(rstN), .baudTick(baudTick), .rx(rx), .data_ready(data_ready),
      .clear_overrun(clear_overrun), .dataOut(d0_data), .data_valid(d0_v),
      .parity_error(d0_pe), .framing_error(d0_fe), .break_detect(d0_bk),
      .overrun_error(d0_ov), .rx_ready(d0_rdy), .new_byte_start(d0_nbs),
      .new_byte_received(d0_nbr));

   uart_rx_framed #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
      .clk(clk), .rstN(rstN), .baudTick(baudTick), .rx(rx), .data_ready(data_ready),
      .clear_overrun(clear_overrun), .dataOut(d1_data), .data_valid(d1_v),
      .parity_error(d1_pe), .framing_error(d1_fe), .break_detect(d1_bk),
      .overrun_error(d1_ov), .rx_ready(d1_rdy), .new_byte_start(d1_nbs),
      .new_byte_received(d1_nbr));

   uart_rx_framed #(.DATA_WIDTH(7), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) u_s2 (
      .clk(clk), .rstN(rstN), .baudTick(baudTick), .rx(rx), .data_ready(data_ready),
      .clear_overrun(clear_overrun), .dataOut(d2_data), .data_valid(d2_v),
      .parity_error(d2_pe), .framing_error(d2_fe), .break_detect(d2_bk),
      .overrun_error(d2_ov), .rx_ready(d2_rdy), .new_byte_start(d2_nbs),
      .new_byte_received(d2_nbr));

   logic [8:0] od [3];
   logic ov [3], ope [3], ofe [3], obk [3], oov [3], ordy [3], onbs [3], onbr [3];
   assign od[0] = {1'b0, d0_data};
   assign od[1] = {1'b0, d1_data};
   assign od[2] = {2'b00, d2_data};
   assign ov[0] = d0_v;   assign ov[1] = d1_v;   assign ov[2] = d2_v;
   assign ope[0] = d0_pe; assign ope[1] = d1_pe; assign ope[2] = d2_pe;
   assign ofe[0] = d0_fe; assign ofe[1] = d1_fe; assign ofe[2] = d2_fe;
   assign obk[0] = d0_bk; assign obk[1] = d1_bk; assign obk[2] = d2_bk;
   assign oov[0] = d0_ov; assign oov[1] = d1_ov; assign oov[2] = d2_ov;
   assign ordy[0] = d0_rdy; assign ordy[1] = d1_rdy; assign ordy[2] = d2_rdy;
   assign onbs[0] = d0_nbs; assign onbs[1] = d1_nbs; assign onbs[2] = d2_nbs;
   assign onbr[0] = d0_nbr; assign onbr[1] = d1_nbr; assign onbr[2] = d2_nbr;

   int vectors = 0, miscompares = 0;
   int tick_idx = 0, ph = 0;
   int cap_cnt [3], nbs_cnt [3], conf_tick [3], bk_cyc [3], v_cyc [3];
   logic [8:0] cap_data [3];
   logic cap_pe [3], cap_fe [3], cap_bk [3];
   logic [8:0] exp_data;
   logic exp_pe, exp_fe, exp_bk;
   int c, n, k, target;
   logic hit;
   logic [8:0] rd;

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      baudTick = (ph == 0);
      if (ph == 0) tick_idx++;
      ph = (ph + 1) % TPB;
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         cap_cnt[i] = 0; nbs_cnt[i] = 0; conf_tick[i] = 0; bk_cyc[i] = 0; v_cyc[i] = 0;
         cap_data[i] = '0; cap_pe[i] = 1'b0; cap_fe[i] = 1'b0; cap_bk[i] = 1'b0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (onbr[i]) begin
               cap_cnt[i]++;
               cap_data[i] = od[i];
               cap_pe[i]   = ope[i];
               cap_fe[i]   = ofe[i];
               cap_bk[i]   = obk[i];
            end
            if (onbs[i]) begin
               nbs_cnt[i]++;
               conf_tick[i] = tick_idx;
            end
            if (obk[i]) bk_cyc[i]++;
            if (ov[i])  v_cyc[i]++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive_bit(input logic b, input bit spike);
      rx = b;
      if (spike) begin
         repeat (BITCLK / 2 - 2) @(negedge clk);
         rx = 1'b0;
         repeat (TPB) @(negedge clk);
         rx = b;
         repeat (BITCLK - BITCLK / 2 + 2 - TPB) @(negedge clk);
      end else begin
         repeat (BITCLK) @(negedge clk);
      end
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * BITCLK) @(negedge clk);
   endtask

   // Transmit one frame in the format of receiver 'dut' and record what it must report.
   task automatic send_frame(input int dut, input logic [8:0] data, input bit par_bad,
                             input logic [1:0] stops, input int spike_bit);
      int dw, pen, podd, sb;
      logic [8:0] d;
      logic p;
      dw = (dut == 2) ? 7 : 8;
      pen = (dut == 0) ? 0 : 1;
      podd = (dut == 2) ? 1 : 0;
      sb = (dut == 2) ? 2 : 1;
      d = data & 9'((1 << dw) - 1);
      p = (^d) ^ podd[0] ^ par_bad;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < dw; i++) drive_bit(d[i], i == spike_bit);
      if (pen != 0) drive_bit(p, 1'b0);
      for (int i = 0; i < sb; i++) drive_bit(stops[i], 1'b0);
      drive_bit(1'b1, 1'b0);
      exp_data = d;
      exp_pe   = (pen != 0) && (((^d) ^ p ^ podd[0]) != 1'b0);
      exp_fe   = (stops[0] == 1'b0) || (sb == 2 && stops[1] == 1'b0);
      exp_bk   = (d == '0) && (stops[0] == 1'b0);
   endtask

   task automatic send_check(input int dut, input string tag, input logic [8:0] data,
                             input bit par_bad, input logic [1:0] stops, input int spike_bit);
      int c0;
      c0 = cap_cnt[dut];
      send_frame(dut, data, par_bad, stops, spike_bit);
      check({tag, "_count"}, cap_cnt[dut] - c0, 1);
      check({tag, "_data"},  cap_data[dut], exp_data);
      check({tag, "_perr"},  cap_pe[dut], exp_pe);
      check({tag, "_ferr"},  cap_fe[dut], exp_fe);
      check({tag, "_break"}, cap_bk[dut], exp_bk);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_data", od[i], 0);
         check("rst_valid", ov[i], 0);
         check("rst_flags", {ope[i], ofe[i], obk[i], oov[i], onbs[i], onbr[i]}, 0);
         check("rst_rx_ready", ordy[i], 1);
      end
      rstN = 1'b1;
      idle(2);

      // 8N1 word with immediate consumption
      c = cap_cnt[0]; n = nbs_cnt[0]; v_cyc[0] = 0;
      fork
         send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
         begin
            repeat (4 * BITCLK) @(negedge clk);
            check("t1_rx_ready_busy", d0_rdy, 0);
         end
      join
      check("t1_count", cap_cnt[0] - c, 1);
      check("t1_start", nbs_cnt[0] - n, 1);
      check("t1_data", cap_data[0], 9'h0A5);
      check("t1_flags", {cap_pe[0], cap_fe[0], cap_bk[0]}, 0);
      check("t1_valid_cycles", v_cyc[0], 1);
      check("t1_rx_ready_idle", d0_rdy, 1);

      for (int i = 0; i < 4; i++) begin
         rd = 9'($urandom_range(0, 255));
         send_check(0, "rand8n1", rd, 1'b0, {1'b1, ($urandom_range(0, 3) != 0)}, -1);
      end

      // Start-bit glitch, then a one-sample spike inside a data bit
      c = cap_cnt[0]; n = nbs_cnt[0];
      rx = 1'b0;
      repeat (3 * TPB) @(negedge clk);
      idle(12);
      check("glitch_count", cap_cnt[0] - c, 0);
      check("glitch_start", nbs_cnt[0] - n, 0);
      check("glitch_valid", d0_v, 0);
      send_check(0, "spike", 9'h03C, 1'b0, 2'b11, 2);

      // Even parity receiver
      idle(12);
      send_check(1, "par_bad", 9'h007, 1'b1, 2'b11, -1);
      send_check(1, "par_good", 9'h007, 1'b0, 2'b11, -1);
      for (int i = 0; i < 3; i++) begin
         rd = 9'($urandom_range(0, 255));
         send_check(1, "rand_par", rd, ($urandom_range(0, 1) != 0), {1'b1, ($urandom_range(0, 3) != 0)}, -1);
      end

      // Overrun, then completion coinciding with an accept
      idle(12);
      data_ready = 1'b0;
      send_frame(0, 9'h011, 1'b0, 2'b11, -1);
      send_frame(0, 9'h022, 1'b0, 2'b11, -1);
      check("ovr_data", d0_data, 8'h22);
      check("ovr_valid", d0_v, 1);
      check("ovr_flag", d0_ov, 1);
      clear_overrun = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      check("ovr_cleared", d0_ov, 0);
      check("ovr_valid_kept", d0_v, 1);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      check("accept_clears_valid", d0_v, 0);
      send_frame(0, 9'h011, 1'b0, 2'b11, -1);
      n = nbs_cnt[0];
      hit = 1'b0;
      fork
         send_frame(0, 9'h022, 1'b0, 2'b11, -1);
         begin
            k = 0;
            while (nbs_cnt[0] == n && k < 20000) begin @(negedge clk); k++; end
            target = conf_tick[0] + OS * 9;
            k = 0;
            while (tick_idx != target && k < 20000) begin @(negedge clk); #1; k++; end
            hit = (tick_idx == target);
            data_ready = 1'b1;
            @(posedge clk);
            #1;
            data_ready = 1'b0;
         end
      join
      check("same_cycle_found", hit, 1);
      check("same_cycle_no_ovr", d0_ov, 0);
      check("same_cycle_valid", d0_v, 1);
      check("same_cycle_data", d0_data, 8'h22);
      data_ready = 1'b1;

      // Line held low for two frame times
      idle(2);
      c = cap_cnt[0]; n = nbs_cnt[0]; bk_cyc[0] = 0;
      rx = 1'b0;
      repeat (20 * BITCLK) @(negedge clk);
      idle(12);
      check("brk_count", cap_cnt[0] - c, 1);
      check("brk_start", nbs_cnt[0] - n, 1);
      check("brk_data", cap_data[0], 0);
      check("brk_ferr", cap_fe[0], 1);
      check("brk_flag", cap_bk[0], 1);
      check("brk_cycles", bk_cyc[0], 1);
      send_check(0, "after_brk", 9'($urandom_range(1, 255)), 1'b0, 2'b11, -1);

      // 7 data bits, odd parity, two stop bits; reset mid-frame
      idle(12);
      send_check(2, "stop2_low", 9'h05A, 1'b0, 2'b01, -1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      check("mid_rx_ready", d2_rdy, 0);
      rstN = 1'b0;
      #1;
      check("arst_data", d2_data, 0);
      check("arst_valid", d2_v, 0);
      check("arst_ferr", d2_fe, 0);
      check("arst_rx_ready", d2_rdy, 1);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      rstN = 1'b1;
      idle(12);
      send_check(2, "post_rst", 9'h02B, 1'b0, 2'b11, -1);
      for (int i = 0; i < 3; i++) begin
         rd = 9'($urandom_range(0, 127));
         send_check(2, "rand_s2", rd, ($urandom_range(0, 1) != 0), 2'($urandom_range(0, 3)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
